axi_wr_scheduler: RTL and testbench
===================================

# axi_wr_scheduler

Per-slave write-path controller for the AXI bridge. It arbitrates the AW/W/B channels of one slave port between the two write-capable masters (M0, M1) and holds one write transaction at a time from AW handshake through B handshake. It routes valid/ready for each channel, exports a one-hot grant that drives the field muxes, and checks that WLAST agrees with AWLEN. One instance sits in front of each slave (S0, S1, SD).

## Interface
Parameters:
- LEN_BITS, default `AXI_LEN_BITS (4): AWLEN width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset; asynchronous, active-low.
- AWVALID_M  in  2  AW valid from master i (bit i).
- AWLEN_M0, AWLEN_M1  in  LEN_BITS  burst length from each master.
- AWREADY_M  out  2  AW ready to master i.
- AWVALID_S, AWREADY_S  out/in  1  slave AW handshake.
- WVALID_M, WLAST_M  in  2  W valid and last from master i.
- WREADY_M  out  2  W ready to master i.
- WVALID_S, WREADY_S  out/in  1  slave W handshake.
- BVALID_S, BREADY_S  in/out  1  slave B handshake.
- BVALID_M  out  2  B valid to master i.
- BREADY_M  in  2  B ready from master i.
- grant  out  2  one-hot owner; 0 when idle. Mux select for AW/W/B fields.
- busy  out  1  state != IDLE.
- len_err  out  1  one-cycle pulse on a WLAST/AWLEN mismatch.

## Operation
- States: IDLE, ADDR, DATA, RESP. Registers: grant, prio (the master favoured next), beats_left (LEN_BITS+1 bits), len_err.
- IDLE → ADDR when any AWVALID_M bit is high.
  - grant = sole requester; if both request, grant = prio.
- ADDR:
  - AWVALID_S = AWVALID_M[g]; AWREADY_M[g] = AWREADY_S; other AWREADY_M = 0.
  - On AWVALID_S && AWREADY_S: beats_left ← AWLEN_Mg + 1 (zero-extended, no overflow); go to DATA.
- DATA:
  - WVALID_S = WVALID_M[g]; WREADY_M[g] = WREADY_S.
  - Each W handshake decrements beats_left.
  - On the handshake with beats_left == 1, go to RESP.
  - len_err pulses the next cycle if WLAST_M[g] != (beats_left == 1) on any handshake beat.
  - The transition is driven by the counter, never by WLAST.
- RESP:
  - BVALID_M[g] = BVALID_S; BREADY_S = BREADY_M[g].
  - On handshake: go to IDLE, grant ← 0, prio ← the other master.
- Outside the matching state:
  - All AW, W and B valid/ready outputs are 0.
  - Non-granted masters always see ready/valid 0.
  - W data presented before the AW handshake is stalled: WREADY_M stays 0 until DATA.
- Once granted, the owner is held even if its AWVALID drops. Protocol violation; no recovery attempted.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, grant = 0, prio = M0, beats_left = 0.
  - busy = 0, len_err = 0.
  - All valid/ready outputs = 0.
- Reset asserted mid-transaction aborts to IDLE immediately. No B is generated.
- Arbitration latency: AWVALID_M seen in IDLE → grant and AWVALID_S high the next cycle.
- Valid/ready routing is combinational from grant and state. No added per-beat latency; one W beat per cycle is sustainable.
- Minimum turnaround:
  - A RESP handshake in cycle n allows a new grant in cycle n+2 (IDLE at n+1, ADDR at n+2).
  - Back-to-back requests therefore alternate M0/M1.
- Single-beat burst (AWLEN = 0): beats_left = 1. The first W handshake moves to RESP.
- AWLEN = max (15): 16 beats, counter holds 16 without wrap.

## Structure
- Shared package gets:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;
  - constant WR_MASTER_CNT = 2.
- Natural sub-module: wr_beat_counter.
  - Load on AW handshake, decrement on W handshake.
  - Outputs last_beat and the registered len_err.
- The top level holds the FSM, the round-robin prio register and the channel routing.

## Test plan
- Reset mid-DATA (M0, AWLEN=3, 2 beats done) → next cycle: grant=0, busy=0, every output 0; a fresh M1 request is then granted normally.
- M0 alone, AWLEN=3, WREADY_S always 1 → AWVALID_S one cycle after AWVALID_M; 4 W beats; RESP; IDLE; grant=2'b01 throughout; prio=M1 afterwards.
- M0 and M1 request the same cycle out of reset → M0 granted first, M1 granted 2 cycles after M0's B handshake, then M0 wins the next tie.
- M1 AWLEN=0 with WLAST=1 on the single beat → RESP after 1 beat, len_err stays 0.
- M0 AWLEN=2 with WLAST on beat 2 → len_err pulses one cycle. Also test WLAST missing on beat 3: len_err pulses. In both cases the FSM enters RESP only after the 3rd handshake.
- M1 drives WVALID before AW; slave holds AWREADY_S=0 for 5 cycles → WREADY_M[1]=0 until AW handshake; BREADY_S tracks BREADY_M[1] only in RESP.

Source files
------------

// File: rtl/axi_wr_scheduler_pkg.sv
// Shared types and constants for the per-slave AXI write scheduler.
// Also holds the two-master round-robin pick used at arbitration time.
package axi_wr_scheduler_pkg;

  localparam int AXI_LEN_BITS  = 4;
  localparam int WR_MASTER_CNT = 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

  // A lone requester wins outright; a tie goes to the favoured master.
  function automatic logic [WR_MASTER_CNT-1:0] rr_pick(
    input logic [WR_MASTER_CNT-1:0] req,
    input logic                     prio
  );
    if (req == 2'b11) return prio ? 2'b10 : 2'b01;
    return req;
  endfunction

endpackage

// File: rtl/axi_wr_scheduler_if.sv
// AW/W/B valid/ready bundle between the two write masters, the scheduler and one slave.
// "slave" is the scheduler's view; "master" is the surrounding fabric's view.
interface axi_wr_scheduler_if
  import axi_wr_scheduler_pkg::*;
#(
  parameter int LEN_BITS = AXI_LEN_BITS
);

  logic [WR_MASTER_CNT-1:0] AWVALID_M;
  logic [LEN_BITS-1:0]      AWLEN_M0;
  logic [LEN_BITS-1:0]      AWLEN_M1;
  logic [WR_MASTER_CNT-1:0] AWREADY_M;
  logic                     AWVALID_S;
  logic                     AWREADY_S;
  logic [WR_MASTER_CNT-1:0] WVALID_M;
  logic [WR_MASTER_CNT-1:0] WLAST_M;
  logic [WR_MASTER_CNT-1:0] WREADY_M;
  logic                     WVALID_S;
  logic                     WREADY_S;
  logic                     BVALID_S;
  logic                     BREADY_S;
  logic [WR_MASTER_CNT-1:0] BVALID_M;
  logic [WR_MASTER_CNT-1:0] BREADY_M;

  modport slave (
    input  AWVALID_M, AWLEN_M0, AWLEN_M1, AWREADY_S,
    input  WVALID_M, WLAST_M, WREADY_S,
    input  BVALID_S, BREADY_M,
    output AWREADY_M, AWVALID_S,
    output WREADY_M, WVALID_S,
    output BVALID_M, BREADY_S
  );

  modport master (
    output AWVALID_M, AWLEN_M0, AWLEN_M1, AWREADY_S,
    output WVALID_M, WLAST_M, WREADY_S,
    output BVALID_S, BREADY_M,
    input  AWREADY_M, AWVALID_S,
    input  WREADY_M, WVALID_S,
    input  BVALID_M, BREADY_S
  );

endinterface

// File: rtl/axi_wr_scheduler_wr_beat_counter.sv
// Remaining-beat counter for the burst in flight: loaded on AW, decremented per W beat.
// Flags (one cycle later) any beat whose WLAST disagrees with the counter.
module axi_wr_scheduler_wr_beat_counter #(
  parameter int LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LEN_BITS-1:0] len,
  input  logic                beat,
  input  logic                wlast,
  output logic                last_beat,
  output logic                len_err
);

  localparam logic [LEN_BITS:0] ONE = {{LEN_BITS{1'b0}}, 1'b1};

  // One extra bit so AWLEN = max loads 2**LEN_BITS without wrapping.
  logic [LEN_BITS:0] beats_left;

  assign last_beat = (beats_left == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left <= '0;
      len_err    <= 1'b0;
    end else begin
      len_err <= beat && (wlast != last_beat);
      if (load)
        beats_left <= {1'b0, len} + ONE;
      else if (beat && beats_left != '0)
        beats_left <= beats_left - ONE;
    end
  end

endmodule

// File: rtl/axi_wr_scheduler.sv
// Per-slave write-path controller: grants AW/W/B of one slave to M0 or M1 and
// holds a single write transaction from AW handshake through B handshake.
module axi_wr_scheduler
  import axi_wr_scheduler_pkg::*;
#(
  parameter int LEN_BITS = AXI_LEN_BITS
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axi_wr_scheduler_if.slave        bus,
  output logic [WR_MASTER_CNT-1:0] grant,
  output logic                     busy,
  output logic                     len_err
);

  wr_state_e state;
  logic      prio;
  logic      sel;
  logic      in_addr, in_data, in_resp;
  logic      aw_hs, w_hs, b_hs;
  logic      last_beat;

  assign sel     = grant[1];
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign in_resp = (state == RESP);

  // Grant is one-hot (or zero), so masking with it routes ready/valid only to the owner.
  assign bus.AWVALID_S = in_addr && bus.AWVALID_M[sel];
  assign bus.AWREADY_M = grant & {WR_MASTER_CNT{in_addr && bus.AWREADY_S}};
  assign bus.WVALID_S  = in_data && bus.WVALID_M[sel];
  assign bus.WREADY_M  = grant & {WR_MASTER_CNT{in_data && bus.WREADY_S}};
  assign bus.BVALID_M  = grant & {WR_MASTER_CNT{in_resp && bus.BVALID_S}};
  assign bus.BREADY_S  = in_resp && bus.BREADY_M[sel];

  assign aw_hs = bus.AWVALID_S && bus.AWREADY_S;
  assign w_hs  = bus.WVALID_S && bus.WREADY_S;
  assign b_hs  = bus.BVALID_S && bus.BREADY_S;

  axi_wr_scheduler_wr_beat_counter #(
    .LEN_BITS (LEN_BITS)
  ) u_beat_counter (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .load      (aw_hs),
    .len       (sel ? bus.AWLEN_M1 : bus.AWLEN_M0),
    .beat      (w_hs),
    .wlast     (bus.WLAST_M[sel]),
    .last_beat (last_beat),
    .len_err   (len_err)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      grant <= '0;
      prio  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.AWVALID_M) begin
            state <= ADDR;
            busy  <= 1'b1;
            grant <= rr_pick(bus.AWVALID_M, prio);
          end
        end
        ADDR: begin
          if (aw_hs) state <= DATA;
        end
        // Leaving DATA is decided by the counter alone; WLAST only feeds len_err.
        DATA: begin
          if (w_hs && last_beat) state <= RESP;
        end
        RESP: begin
          if (b_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            grant <= '0;
            prio  <= grant[0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Self-checking bench for axi_wr_scheduler: directed vector table, hand-written
// reset sequences and randomized transactions against a transaction-level model.
module tb_axi_wr_scheduler;

  localparam int LB = 4;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [1:0] grant;
  logic       busy;
  logic       len_err;

  axi_wr_scheduler_if #(.LEN_BITS(LB)) bus();

  axi_wr_scheduler #(.LEN_BITS(LB)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int prio_m = 0;   // model: master favoured on the next tie

  typedef struct {
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] exp_grant;
    int         err_beat;   // beat index with wrong WLAST, -1 for none
    int         aw_stall;
    bit         early_w;
    int         exp_errs;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.AWVALID_M = 2'b00;
    bus.AWLEN_M0  = 4'd0;
    bus.AWLEN_M1  = 4'd0;
    bus.AWREADY_S = 1'b0;
    bus.WVALID_M  = 2'b00;
    bus.WLAST_M   = 2'b00;
    bus.WREADY_S  = 1'b0;
    bus.BVALID_S  = 1'b0;
    bus.BREADY_M  = 2'b00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},     32'(grant), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_len_err"},   32'(len_err), 0);
    chk({tag, "_awvalid_s"}, 32'(bus.AWVALID_S), 0);
    chk({tag, "_awready_m"}, 32'(bus.AWREADY_M), 0);
    chk({tag, "_wvalid_s"},  32'(bus.WVALID_S), 0);
    chk({tag, "_wready_m"},  32'(bus.WREADY_M), 0);
    chk({tag, "_bvalid_m"},  32'(bus.BVALID_M), 0);
    chk({tag, "_bready_s"},  32'(bus.BREADY_S), 0);
  endtask

  // One full transaction starting from IDLE; g is the index of the expected owner.
  task automatic run_txn(input logic [1:0] req, input logic [3:0] l0, input logic [3:0] l1,
                         input int g, input int err_beat, input int aw_stall,
                         input bit early_w, input int exp_errs);
    logic [1:0] oh, oth;
    int         n, done, cyc, errs_seen;
    bit         wv;
    oh  = (g == 1) ? 2'b10 : 2'b01;
    oth = ~oh;
    n   = ((g == 1) ? int'(l1) : int'(l0)) + 1;

    @(negedge ACLK);
    clear_in();
    bus.AWVALID_M = req;
    bus.AWLEN_M0  = l0;
    bus.AWLEN_M1  = l1;
    bus.WVALID_M  = early_w ? oh : 2'b00;
    bus.AWREADY_S = 1'b1;
    #1;
    chk("idle_grant",     32'(grant), 0);
    chk("idle_busy",      32'(busy), 0);
    chk("idle_awready_m", 32'(bus.AWREADY_M), 0);
    chk("idle_awvalid_s", 32'(bus.AWVALID_S), 0);
    chk("idle_wready_m",  32'(bus.WREADY_M), 0);

    for (int c = 0; c <= aw_stall; c++) begin
      @(negedge ACLK);
      bus.AWREADY_S = (c == aw_stall);
      #1;
      chk("addr_grant",     32'(grant), 32'(oh));
      chk("addr_busy",      32'(busy), 1);
      chk("addr_awvalid_s", 32'(bus.AWVALID_S), 1);
      chk("addr_awready_m", 32'(bus.AWREADY_M), (c == aw_stall) ? 32'(oh) : 0);
      chk("addr_wready_m",  32'(bus.WREADY_M), 0);
      chk("addr_wvalid_s",  32'(bus.WVALID_S), 0);
    end

    done = 0; cyc = 0; errs_seen = 0;
    while (done < n && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
      bus.AWVALID_M = 2'b00;
      bus.AWREADY_S = 1'b0;
      wv = ($urandom_range(3) != 0);
      bus.WVALID_M[g]     = wv;
      bus.WVALID_M[1 - g] = ($urandom_range(1) != 0);
      bus.WLAST_M         = 2'($urandom_range(3));
      bus.WLAST_M[g]      = (done == n - 1) ^ (done == err_beat);
      bus.WREADY_S        = ($urandom_range(3) != 0);
      bus.BVALID_S        = 1'b1;
      bus.BREADY_M        = 2'b11;
      #1;
      chk("data_grant",    32'(grant), 32'(oh));
      chk("data_wready_m", 32'(bus.WREADY_M), bus.WREADY_S ? 32'(oh) : 0);
      chk("data_wvalid_s", 32'(bus.WVALID_S), 32'(wv));
      chk("data_bvalid_m", 32'(bus.BVALID_M), 0);
      chk("data_bready_s", 32'(bus.BREADY_S), 0);
      if (len_err) errs_seen++;
      if (wv && bus.WREADY_S) done++;
    end
    if (done < n) chk("data_timeout", 32'(done), 32'(n));

    @(negedge ACLK);
    clear_in();
    bus.WVALID_M = oh;
    bus.WLAST_M  = oh;
    bus.WREADY_S = 1'b1;
    bus.BVALID_S = 1'b1;
    bus.BREADY_M = oth;
    #1;
    chk("resp_wready_m", 32'(bus.WREADY_M), 0);
    chk("resp_wvalid_s", 32'(bus.WVALID_S), 0);
    chk("resp_bvalid_m", 32'(bus.BVALID_M), 32'(oh));
    chk("resp_bready_s_other", 32'(bus.BREADY_S), 0);
    chk("resp_grant",    32'(grant), 32'(oh));
    if (len_err) errs_seen++;

    @(negedge ACLK);
    bus.BREADY_M = 2'b11;
    #1;
    chk("resp_bready_s", 32'(bus.BREADY_S), 1);
    chk("resp_bvalid_m2", 32'(bus.BVALID_M), 32'(oh));
    if (len_err) errs_seen++;
    chk("len_err_pulses", 32'(errs_seen), 32'(exp_errs));
    prio_m = 1 - g;
  endtask

  initial begin
    vecs[0] = '{2'b11, 4'd3,  4'd0,  2'b01, -1, 0, 1'b0, 0};
    vecs[1] = '{2'b11, 4'd1,  4'd0,  2'b10, -1, 0, 1'b0, 0};
    vecs[2] = '{2'b11, 4'd2,  4'd5,  2'b01,  1, 0, 1'b0, 1};
    vecs[3] = '{2'b01, 4'd2,  4'd0,  2'b01,  2, 0, 1'b0, 1};
    vecs[4] = '{2'b10, 4'd0,  4'd0,  2'b10, -1, 5, 1'b1, 0};
    vecs[5] = '{2'b01, 4'd3,  4'd0,  2'b01, -1, 0, 1'b0, 0};
    vecs[6] = '{2'b11, 4'd15, 4'd15, 2'b10, -1, 1, 1'b0, 0};
    vecs[7] = '{2'b10, 4'd0,  4'd15, 2'b10, 15, 0, 1'b1, 1};
    vecs[8] = '{2'b11, 4'd4,  4'd4,  2'b01,  0, 2, 1'b1, 1};
    vecs[9] = '{2'b11, 4'd0,  4'd0,  2'b10,  0, 0, 1'b0, 1};

    // Reset with every input active: nothing may leak through.
    ARESETn = 1'b0;
    clear_in();
    bus.AWVALID_M = 2'b11;
    bus.AWREADY_S = 1'b1;
    bus.WVALID_M  = 2'b11;
    bus.WLAST_M   = 2'b11;
    bus.WREADY_S  = 1'b1;
    bus.BVALID_S  = 1'b1;
    bus.BREADY_M  = 2'b11;
    repeat (2) @(negedge ACLK);
    #1;
    chk_all_zero("reset");
    @(negedge ACLK);
    clear_in();
    ARESETn = 1'b1;
    prio_m  = 0;

    foreach (vecs[i])
      run_txn(vecs[i].req, vecs[i].l0, vecs[i].l1, vecs[i].exp_grant[1] ? 1 : 0,
              vecs[i].err_beat, vecs[i].aw_stall, vecs[i].early_w, vecs[i].exp_errs);

    // Reset asserted in the middle of a 4-beat M0 burst, after 2 beats.
    @(negedge ACLK);
    clear_in();
    bus.AWVALID_M = 2'b01;
    bus.AWLEN_M0  = 4'd3;
    #1;
    chk("mr_idle_busy", 32'(busy), 0);
    @(negedge ACLK);
    bus.AWREADY_S = 1'b1;
    #1;
    chk("mr_awready_m", 32'(bus.AWREADY_M), 32'h1);
    for (int b = 0; b < 3; b++) begin
      @(negedge ACLK);
      bus.AWVALID_M = 2'b00;
      bus.AWREADY_S = 1'b0;
      bus.WVALID_M  = 2'b01;
      bus.WREADY_S  = 1'b1;
      bus.BVALID_S  = 1'b1;
      bus.BREADY_M  = 2'b11;
      #1;
      chk("mr_wready_m", 32'(bus.WREADY_M), 32'h1);
    end
    ARESETn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge ACLK);
    clear_in();
    ARESETn = 1'b1;
    prio_m  = 0;
    run_txn(2'b10, 4'd1, 4'd2, 1, -1, 1, 1'b0, 0);

    // Randomized transactions checked against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] req;
      logic [3:0] l0, l1;
      int         g, n, eb;
      req = 2'($urandom_range(3, 1));
      l0  = 4'($urandom_range(15));
      l1  = 4'($urandom_range(15));
      g   = (req == 2'b11) ? prio_m : (req[1] ? 1 : 0);
      n   = ((g == 1) ? int'(l1) : int'(l0)) + 1;
      eb  = ($urandom_range(1) != 0) ? int'($urandom_range(n - 1)) : -1;
      run_txn(req, l0, l1, g, eb, int'($urandom_range(3)), ($urandom_range(1) != 0),
              (eb >= 0) ? 1 : 0);
    end

    @(negedge ACLK);
    clear_in();
    #1;
    chk_all_zero("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
